// File: rtl/control_pipeline.sv
// control_pipeline: RV32I opcode decoder feeding a NUM_STAGES-deep registered
// control pipeline (stage 1 = EX, 2 = MEM, 3 = WB by default). It carries a
// valid bit per stage. It supports a global stall and flush bubble insertion,
// and it detects load-use hazards with a ready handshake back to decode.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   valid_in        decode presents an instruction
//   ready_out       instruction accepted this cycle (!stall_in && !hazard_stall)
//   opcode          instruction[6:0]
//   rd_addr         destination register of the incoming instruction
//   rs1_addr        source register 1 of the incoming instruction
//   rs2_addr        source register 2 of the incoming instruction
//   stall_in        freeze all stages
//   flush_in        kill the instruction entering stage 1
//   hazard_stall    load-use hazard against stage 1 (combinational)
//   ctrl_out        stage k bundle at [k*CTRL_W-1 -: CTRL_W], k = 1..NUM_STAGES
//   rd_out          stage k rd, same packing
//   retired_cnt     (CTRL_PERF_CNT_EN only) valid bundles leaving the last stage
//   bubble_cnt      (CTRL_PERF_CNT_EN only) bubbles inserted by flush or hazard
//
// Optional feature macro: CTRL_PERF_CNT_EN adds the two performance counters.

package control_pipeline_pkg;

  localparam int unsigned CTRL_W    = 13;
  localparam int unsigned ALU_SEL_W = 4;
  localparam int unsigned OPCODE_W  = 7;

  // ALU select encodings shared with the datapath
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_ARITHMETIC = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_LOAD       = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_STORE      = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_BRANCH     = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_JAL        = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_JALR       = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_LUI        = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_SELECT_AUIPC      = 4'd8;

  // RV32I major opcodes
  localparam logic [OPCODE_W-1:0] OPCODE_ALU    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;

  // Control bundle, MSB first: valid is bit 12, alu_select is bits [3:0]
  typedef struct packed {
    logic                 valid;
    logic                 is_jalr;
    logic                 is_jal;
    logic                 is_branch;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic                 mem_data_select;
    logic                 reg_b_select;
    logic                 regfile_wr_en;
    logic [ALU_SEL_W-1:0] alu_select;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  output logic                             ready_out,
  input  logic [OPCODE_W-1:0]              opcode,
  input  logic [REG_ADDR_W-1:0]            rd_addr,
  input  logic [REG_ADDR_W-1:0]            rs1_addr,
  input  logic [REG_ADDR_W-1:0]            rs2_addr,
  input  logic                             stall_in,
  input  logic                             flush_in,
  output logic                             hazard_stall,
  output logic [NUM_STAGES*CTRL_W-1:0]     ctrl_out,
  output logic [NUM_STAGES*REG_ADDR_W-1:0] rd_out
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                      retired_cnt,
  output logic [31:0]                      bubble_cnt
`endif
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  ctrl_t                 ctrl_q [NUM_STAGES];
  logic [REG_ADDR_W-1:0] rd_q   [NUM_STAGES];

  ctrl_t                 dec_bundle;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  known;
  logic                  load_in_ex;
  logic                  insert_bubble;

  // Opcode decode; an unknown opcode or an absent instruction is a bubble
  always_comb begin
    dec_bundle = CTRL_BUBBLE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    known      = 1'b1;
    case (opcode)
      OPCODE_ALU: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.reg_b_select  = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_ARITHMETIC;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPCODE_ALUI: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_ARITHMETIC;
        rs1_used = 1'b1;
      end
      OPCODE_LOAD: begin
        dec_bundle.regfile_wr_en   = 1'b1;
        dec_bundle.mem_data_select = 1'b1;
        dec_bundle.mem_rd_en       = 1'b1;
        dec_bundle.alu_select      = ALU_SELECT_LOAD;
        rs1_used = 1'b1;
      end
      OPCODE_STORE: begin
        dec_bundle.mem_wr_en  = 1'b1;
        dec_bundle.alu_select = ALU_SELECT_STORE;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPCODE_BRANCH: begin
        dec_bundle.reg_b_select = 1'b1;
        dec_bundle.is_branch    = 1'b1;
        dec_bundle.alu_select   = ALU_SELECT_BRANCH;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPCODE_JAL: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.reg_b_select  = 1'b1;
        dec_bundle.is_jal        = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_JAL;
      end
      OPCODE_JALR: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.reg_b_select  = 1'b1;
        dec_bundle.is_jalr       = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_JALR;
        rs1_used = 1'b1;
      end
      OPCODE_LUI: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_LUI;
      end
      OPCODE_AUIPC: begin
        dec_bundle.regfile_wr_en = 1'b1;
        dec_bundle.alu_select    = ALU_SELECT_AUIPC;
      end
      default: known = 1'b0;
    endcase
    dec_bundle.valid = valid_in && known;
    if (!dec_bundle.valid) begin
      dec_bundle = CTRL_BUBBLE;
    end
    dec_rd = dec_bundle.valid ? rd_addr : '0;
  end

  // Load-use hazard: a load in EX writing a register the incoming op reads.
  // x0 is excluded because its writes are discarded.
  always_comb begin
    load_in_ex   = ctrl_q[0].valid && ctrl_q[0].mem_rd_en && (rd_q[0] != '0);
    hazard_stall = valid_in && load_in_ex &&
                   ((rs1_used && (rs1_addr == rd_q[0])) ||
                    (rs2_used && (rs2_addr == rd_q[0])));
    ready_out    = !stall_in && !hazard_stall;
  end

  // Flush wins even during a stall; a hazard bubble only applies when advancing
  assign insert_bubble = flush_in || (!stall_in && hazard_stall);

  // Stage 1 (EX): bubble, hold or load the decoded instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q[0] <= CTRL_BUBBLE;
      rd_q[0]   <= '0;
    end else if (insert_bubble) begin
      ctrl_q[0] <= CTRL_BUBBLE;
      rd_q[0]   <= '0;
    end else if (!stall_in) begin
      ctrl_q[0] <= dec_bundle;
      rd_q[0]   <= dec_rd;
    end
  end

  // Stages 2..N shift forward unless stalled
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctrl_q[k] <= CTRL_BUBBLE;
        rd_q[k]   <= '0;
      end else if (!stall_in) begin
        ctrl_q[k] <= ctrl_q[k-1];
        rd_q[k]   <= rd_q[k-1];
      end
    end
  end

  // Flatten per-stage registers; stage 1 occupies the least significant slice
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign ctrl_out[k*CTRL_W +: CTRL_W]         = ctrl_q[k];
    assign rd_out[k*REG_ADDR_W +: REG_ADDR_W]   = rd_q[k];
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] bubble_q;

  // Free-running, wrapping event counters sampled on advancing edges only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      bubble_q  <= '0;
    end else if (!stall_in) begin
      if (ctrl_q[LAST].valid) begin
        retired_q <= retired_q + 32'd1;
      end
      if (flush_in || hazard_stall) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;
`endif

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Decodes the RV32I opcode into a control bundle and carries it through NUM_STAGES registered pipeline stages: stage 1 = EX, stage 2 = MEM, stage 3 = WB by default.
- Adds a valid bit, global stall, flush bubble insertion and load-use hazard detection, with a ready handshake back to fetch/decode.
- Sits between the ID stage and the datapath. Each datapath stage reads its own bundle slice.

Parameters:
NUM_STAGES, 3, number of registered control stages (min 2, max 8).
REG_ADDR_W, 5, register-file address width.
CTRL_W, 13, bundle width (localparam, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
valid_in  in  1  decode stage presents an instruction.
ready_out  out  1  instruction accepted this cycle; equals !stall_in && !hazard_stall.
opcode  in  7  instruction[6:0].
rd_addr  in  REG_ADDR_W  destination register.
rs1_addr  in  REG_ADDR_W  source register 1.
rs2_addr  in  REG_ADDR_W  source register 2.
stall_in  in  1  freeze all stages (e.g. memory wait).
flush_in  in  1  kill the instruction entering stage 1 (taken branch/jump).
hazard_stall  out  1  load-use hazard detected (combinational).
ctrl_out  out  NUM_STAGES*CTRL_W  stage k bundle at bits [k*CTRL_W-1 -: CTRL_W], k = 1..NUM_STAGES.
rd_out  out  NUM_STAGES*REG_ADDR_W  rd per stage, same packing.

Behaviour:
- Bundle bits:
  - [3:0] alu_select, using the `ALU_SELECT_* encodings from common/isa.svh
  - [4] regfile_wr_en
  - [5] reg_b_select
  - [6] mem_data_select
  - [7] mem_rd_en
  - [8] mem_wr_en
  - [9] is_branch
  - [10] is_jal
  - [11] is_jalr
  - [12] valid
- Decode (combinational, team's existing opcode table):
  - ALU: wr, b_sel, ARITHMETIC
  - ALUI: wr, ARITHMETIC
  - LOAD: wr, data_sel, rd_en, LOAD
  - STORE: wr_en, STORE
  - BRANCH: b_sel, branch, BRANCH
  - JAL: wr, b_sel, jal, JAL
  - JALR: wr, b_sel, jalr, JALR
  - LUI: wr, LUI
  - AUIPC: wr, AUIPC
  - Unknown opcode: all-zero bundle with valid=0 (treated as a bubble).
- Bubble = all-zero bundle with rd=0.
- Reset: every stage bundle and rd cleared to a bubble; ready_out follows its equation.
- Source usage for hazard checks:
  - rs1 used by ALU, ALUI, LOAD, STORE, BRANCH, JALR.
  - rs2 used by ALU, STORE, BRANCH.
- hazard_stall = 1 when all of the following hold:
  - valid_in
  - stage 1 is valid with mem_rd_en=1
  - stage 1 rd != 0
  - stage 1 rd matches a used rs of the incoming instruction
- Register x0 never raises a hazard.
- Per-edge priority, highest first:
  1. rst: all stages become bubbles.
  2. stall_in: stages 2..N hold. Stage 1 holds, except when flush_in=1, in which case stage 1 becomes a bubble.
  3. flush_in: stage 1 becomes a bubble; stages 2..N advance.
  4. hazard_stall: stage 1 becomes a bubble; stages 2..N advance; the incoming instruction is not accepted and must be re-presented.
  5. Normal: stage 1 takes the decoded bundle with valid = valid_in && opcode known; stage k takes stage k-1.
- Latency: an accepted instruction's bundle appears in stage k k cycles after acceptance.
- Unchanged while stalled.
- Stage N output is dropped on the next advance; there is no backpressure beyond stall_in.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds two outputs, retired_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
  - retired_cnt increments on each non-stalled edge where stage N is valid.
  - bubble_cnt increments on each non-stalled edge where stage 1 is loaded with a bubble because of flush_in or hazard_stall.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then valid_in=1, opcode 0110011 (ALU), rd=5 → ctrl_out stage 1 has wr=1, b_sel=1, alu=ARITHMETIC, valid=1 after 1 clk; stage 3 holds the same bundle and rd=5 after 3 clks.
- LOAD rd=7, then ALU rs2=7 → hazard_stall=1 and ready_out=0 for one cycle; stage 1 gets a bubble; ALU accepted the next cycle; no hazard if rd=0.
- STORE with rs2=7 behind LOAD rd=7 → hazard. LUI behind LOAD rd=7 with rs1 field=7 → no hazard (rs1 unused).
- stall_in held 4 cycles with the pipeline full → all stages unchanged, ready_out=0. flush_in during the stall → only stage 1 becomes a bubble.
- opcode 1111111 with valid_in=1 → stage 1 valid=0, all controls 0. Assert rst mid-stream → all outputs cleared asynchronously before the next edge.
- CTRL_PERF_CNT_EN: 10 ALU ops, 1 flush, 1 load-use → retired_cnt=11 (10 ALU + load), bubble_cnt=2. Preload retired_cnt at 0xFFFFFFFF → wraps to 0.
